// File: rtl/memory_port_arbiter.sv
// ============================================================================
//  Module      : memory_port_arbiter
//  Description : Shares one single-port data RAM and the UART transmitter
//                between the memory functional unit (M) and the loader (L).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_port_arbiter #(
   parameter int                  ADDR_W      = 10,
   parameter int                  RAM_LATENCY = 2,
   parameter int                  DATA_W      = 32,
   parameter int                  INSTR_W     = 6,
   parameter int                  RSV_ID_W    = 4,
   parameter logic [INSTR_W-1:0]  I_STORE     = INSTR_W'(8),
   parameter logic [INSTR_W-1:0]  I_STOREB    = INSTR_W'(9),
   parameter logic [INSTR_W-1:0]  I_STORER    = INSTR_W'(10),
   parameter logic [INSTR_W-1:0]  I_OUTPUT    = INSTR_W'(15)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         m_valid,
   input  logic [INSTR_W-1:0]           m_opcode,
   input  logic [RSV_ID_W-1:0]          m_rsv_id,
   input  logic [DATA_W-1:0]            m_address,
   input  logic [DATA_W-1:0]            m_data,
   output logic                         m_ready,
   input  logic                         l_valid,
   input  logic                         l_we,
   input  logic [ADDR_W-1:0]            l_addr,
   input  logic [DATA_W-1:0]            l_wdata,
   output logic                         l_ready,
   output logic                         l_rvalid,
   output logic [DATA_W-1:0]            l_rdata,
   output logic                         ram_en,
   output logic                         ram_we,
   output logic [ADDR_W-1:0]            ram_addr,
   output logic [DATA_W-1:0]            ram_wdata,
   input  logic [DATA_W-1:0]            ram_rdata,
   output logic                         tx_valid,
   output logic [7:0]                   tx_data,
   input  logic                         tx_ready,
   output logic [RSV_ID_W+DATA_W-1:0]   cdb,
   output logic                         cdb_valid,
   input  logic                         cdb_ready,
   output logic                         busy
);

   localparam logic [2:0] c_lat = 3'(RAM_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_RESP = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_last_l;      // 1: L won the last grant
   logic                  r_owner_l;
   logic [2:0]            r_cnt;
   logic [RSV_ID_W-1:0]   r_tag;
   logic [DATA_W-1:0]     r_cdb_data;
   logic                  r_cdb_valid;
   logic                  r_l_rvalid;
   logic [DATA_W-1:0]     r_l_rdata;
   logic                  r_tx_valid;
   logic [7:0]            r_tx_data;

   logic                  w_idle;
   logic                  w_grant_m;
   logic                  w_grant_l;
   logic                  w_m_write;
   logic                  w_m_out;
   logic                  w_m_read;
   logic                  w_capture;
   logic                  w_unused;

   // Accept path is gated by rst so every output reads zero while reset is held.
   assign w_idle    = (r_state == S_IDLE) && !rst;
   assign w_grant_m = w_idle && m_valid && (!l_valid || r_last_l);
   assign w_grant_l = w_idle && l_valid && (!m_valid || !r_last_l);
   assign w_m_write = (m_opcode == I_STORE) || (m_opcode == I_STOREB) || (m_opcode == I_STORER);
   assign w_m_out   = (m_opcode == I_OUTPUT);
   assign w_m_read  = !w_m_write && !w_m_out;
   assign w_capture = (r_state == S_READ) && (r_cnt == c_lat);
   assign w_unused  = &{1'b0, m_address[DATA_W-1:ADDR_W]};

   assign m_ready   = w_grant_m;
   assign l_ready   = w_grant_l;
   assign ram_en    = w_grant_l || (w_grant_m && !w_m_out);
   assign ram_we    = w_grant_l ? l_we : (w_grant_m && w_m_write);
   assign ram_addr  = w_grant_l ? l_addr  : (w_grant_m ? m_address[ADDR_W-1:0] : '0);
   assign ram_wdata = w_grant_l ? l_wdata : (w_grant_m ? m_data : '0);

   assign l_rvalid  = r_l_rvalid;
   assign l_rdata   = r_l_rdata;
   assign tx_valid  = r_tx_valid;
   assign tx_data   = r_tx_data;
   assign cdb_valid = r_cdb_valid;
   assign cdb       = {r_tag, r_cdb_data};
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_m) begin
               if (w_m_out) begin
                  w_next = S_OUT;
               end else if (w_m_read) begin
                  w_next = S_READ;
               end
            end else if (w_grant_l && !l_we) begin
               w_next = S_READ;
            end
         end
         S_READ: begin
            if (w_capture) begin
               w_next = r_owner_l ? S_IDLE : S_RESP;
            end
         end
         S_RESP: begin
            if (cdb_ready) begin
               w_next = S_IDLE;
            end
         end
         S_OUT: begin
            if (tx_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_l    <= 1'b1;
         r_owner_l   <= 1'b0;
         r_cnt       <= 3'd0;
         r_tag       <= '0;
         r_cdb_data  <= '0;
         r_cdb_valid <= 1'b0;
         r_l_rvalid  <= 1'b0;
         r_l_rdata   <= '0;
         r_tx_valid  <= 1'b0;
         r_tx_data   <= 8'd0;
      end else begin
         r_l_rvalid <= 1'b0;
         if (w_grant_m || w_grant_l) begin
            r_last_l <= w_grant_l;
         end
         if (w_grant_m && w_m_read) begin
            r_tag     <= m_rsv_id;
            r_owner_l <= 1'b0;
            r_cnt     <= 3'd1;
         end else if (w_grant_l && !l_we) begin
            r_owner_l <= 1'b1;
            r_cnt     <= 3'd1;
         end else if (r_state == S_READ) begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_capture) begin
            if (r_owner_l) begin
               r_l_rvalid <= 1'b1;
               r_l_rdata  <= ram_rdata;
            end else begin
               r_cdb_valid <= 1'b1;
               r_cdb_data  <= ram_rdata;
            end
         end
         if ((r_state == S_RESP) && cdb_ready) begin
            r_cdb_valid <= 1'b0;
         end
         if (w_grant_m && w_m_out) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= m_data[7:0];
         end
         if ((r_state == S_OUT) && tx_ready) begin
            r_tx_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
// ============================================================================
//  Module      : tb_memory_port_arbiter
//  Description : Scoreboard bench for memory_port_arbiter with a 2-cycle RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_port_arbiter;

   localparam logic [5:0] OP_LOAD   = 6'h01;
   localparam logic [5:0] OP_STORE  = 6'h08;
   localparam logic [5:0] OP_STOREB = 6'h09;
   localparam logic [5:0] OP_STORER = 6'h0A;
   localparam logic [5:0] OP_OUTPUT = 6'h0F;

   logic        clk, rst;
   logic        m_valid, m_ready;
   logic [5:0]  m_opcode;
   logic [3:0]  m_rsv_id;
   logic [31:0] m_address, m_data;
   logic        l_valid, l_we, l_ready, l_rvalid;
   logic [9:0]  l_addr;
   logic [31:0] l_wdata, l_rdata;
   logic        ram_en, ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        tx_valid, tx_ready;
   logic [7:0]  tx_data;
   logic [35:0] cdb;
   logic        cdb_valid, cdb_ready, busy;

   memory_port_arbiter #(
      .ADDR_W(10), .RAM_LATENCY(2), .DATA_W(32), .INSTR_W(6), .RSV_ID_W(4),
      .I_STORE(OP_STORE), .I_STOREB(OP_STOREB), .I_STORER(OP_STORER), .I_OUTPUT(OP_OUTPUT)
   ) dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_opcode(m_opcode), .m_rsv_id(m_rsv_id),
      .m_address(m_address), .m_data(m_data), .m_ready(m_ready),
      .l_valid(l_valid), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_ready(l_ready), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .cdb(cdb), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM with two-cycle read latency.
   logic [31:0] mem [0:1023];
   logic [31:0] rd_stage;
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      rd_stage  = 32'd0;
      ram_rdata = 32'd0;
   end
   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_en && !ram_we) rd_stage <= mem[ram_addr];
      ram_rdata <= rd_stage;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic [1:0]  grant_q [$];
   logic [31:0] l_q [$];
   logic [35:0] cdb_q [$];
   logic [7:0]  tx_q [$];
   int          rd_cyc_q [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents something.
   initial begin
      logic prev_cdb;
      int   c0;
      prev_cdb = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rd_cyc_q.delete();
            prev_cdb = 1'b0;
         end else begin
            if (m_ready || l_ready) begin
               if (grant_q.size() == 0) fail("grant_unexpected");
               else chk("grant", {m_ready, l_ready}, grant_q.pop_front());
               if ((l_ready && !l_we) ||
                   (m_ready && !(m_opcode inside {OP_STORE, OP_STOREB, OP_STORER, OP_OUTPUT})))
                  rd_cyc_q.push_back(cyc);
            end
            if (l_rvalid) begin
               if (l_q.size() == 0) fail("l_rvalid_unexpected");
               else chk("l_rdata", l_rdata, l_q.pop_front());
               if (rd_cyc_q.size() != 0) begin
                  c0 = rd_cyc_q.pop_front();
                  chk("l_rd_latency", cyc - c0, 3);
               end
            end
            if (cdb_valid && !prev_cdb && rd_cyc_q.size() != 0) begin
               c0 = rd_cyc_q.pop_front();
               chk("cdb_latency", cyc - c0, 3);
            end
            if (cdb_valid && cdb_ready) begin
               if (cdb_q.size() == 0) fail("cdb_unexpected");
               else chk("cdb", cdb, cdb_q.pop_front());
            end
            if (tx_valid && tx_ready) begin
               if (tx_q.size() == 0) fail("tx_unexpected");
               else chk("tx_data", tx_data, tx_q.pop_front());
            end
            prev_cdb = cdb_valid;
         end
      end
   end

   task automatic l_req(input logic we, input logic [9:0] a, input logic [31:0] d);
      int n;
      n = 0;
      l_valid = 1'b1; l_we = we; l_addr = a; l_wdata = d;
      @(negedge clk);
      while (!l_ready && n < 50) begin n++; @(negedge clk); end
      if (!l_ready) fail("l_accept_timeout");
      else chk("l_ram_drive", {ram_en, ram_we, ram_addr}, {1'b1, we, a});
      step();
      l_valid = 1'b0;
   endtask

   task automatic m_req(input logic [5:0] op, input logic [3:0] tag, input logic [31:0] a,
                        input logic [31:0] d, output int waits);
      logic is_out, is_st;
      logic [9:0] ea;
      is_out = (op == OP_OUTPUT);
      is_st  = (op == OP_STORE) || (op == OP_STOREB) || (op == OP_STORER);
      ea     = is_out ? 10'd0 : a[9:0];
      m_valid = 1'b1; m_opcode = op; m_rsv_id = tag; m_address = a; m_data = d;
      waits = 0;
      @(negedge clk);
      while (!m_ready && waits < 50) begin waits++; @(negedge clk); end
      if (!m_ready) fail("m_accept_timeout");
      else chk("m_ram_drive", {ram_en, ram_we, ram_addr}, {!is_out, is_st, ea});
      step();
      m_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((grant_q.size() + l_q.size() + cdb_q.size() + tx_q.size()) != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) fail("drain_timeout");
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      rst = 1'b1;
      m_valid = 1'b0; m_opcode = OP_LOAD; m_rsv_id = 4'd0; m_address = 32'd0; m_data = 32'd0;
      l_valid = 1'b0; l_we = 1'b0; l_addr = 10'd0; l_wdata = 32'd0;
      tx_ready = 1'b1; cdb_ready = 1'b1;

      // Reset: requests present but nothing may be granted or driven.
      step();
      m_valid = 1'b1; l_valid = 1'b1;
      @(negedge clk);
      chk("rst_ctrl", {m_ready, l_ready, ram_en, ram_we, busy, l_rvalid, cdb_valid, tx_valid}, 8'h00);
      chk("rst_cdb", cdb, 36'd0);
      chk("rst_data", {ram_addr, tx_data, l_rdata}, 50'd0);
      step();
      m_valid = 1'b0; l_valid = 1'b0;
      rst = 1'b0;
      step();

      // 1: loader write then read back.
      grant_q.push_back(2'b01);
      l_req(1'b1, 10'h005, 32'hDEADBEEF);
      grant_q.push_back(2'b01);
      l_q.push_back(32'hDEADBEEF);
      l_req(1'b0, 10'h005, 32'h0);
      drain();

      // 2: M load (upper address bits ignored) with CDB backpressure.
      cdb_ready = 1'b0;
      grant_q.push_back(2'b10);
      cdb_q.push_back({4'd3, 32'hDEADBEEF});
      m_req(OP_LOAD, 4'd3, 32'h0000_0405, 32'h0, w);
      n = 0;
      @(negedge clk);
      while (!cdb_valid && n < 10) begin n++; @(negedge clk); end
      if (!cdb_valid) fail("cdb_valid_timeout");
      for (int i = 0; i < 3; i++) begin
         chk("cdb_hold", {cdb_valid, busy, cdb}, {1'b1, 1'b1, 4'd3, 32'hDEADBEEF});
         step();
         if (i == 2) cdb_ready = 1'b1;
         @(negedge clk);
      end
      step();
      @(negedge clk);
      chk("resp_done", {busy, cdb_valid}, 2'b00);
      step();
      drain();

      // 3: both requesters writing every cycle from reset alternate M,L,M,L.
      rst = 1'b1;
      step();
      rst = 1'b0;
      grant_q.push_back(2'b10); grant_q.push_back(2'b01);
      grant_q.push_back(2'b10); grant_q.push_back(2'b01);
      m_valid = 1'b1; m_opcode = OP_STORER; m_address = 32'h10; m_data = 32'h11111111;
      l_valid = 1'b1; l_we = 1'b1; l_addr = 10'h020; l_wdata = 32'h22222222;
      repeat (4) @(negedge clk);
      step();
      m_valid = 1'b0; l_valid = 1'b0;
      drain();
      grant_q.push_back(2'b01);
      l_q.push_back(32'h11111111);
      l_req(1'b0, 10'h010, 32'h0);
      drain();

      // 4: output with UART backpressure; a pending load must wait.
      tx_ready = 1'b0;
      grant_q.push_back(2'b10);
      tx_q.push_back(8'h41);
      m_req(OP_OUTPUT, 4'd0, 32'h0, 32'h141, w);
      grant_q.push_back(2'b10);
      cdb_q.push_back({4'd5, 32'h22222222});
      m_valid = 1'b1; m_opcode = OP_LOAD; m_rsv_id = 4'd5; m_address = 32'h20;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("out_hold", {tx_valid, tx_data, cdb_valid, m_ready, busy}, {1'b1, 8'h41, 1'b0, 1'b0, 1'b1});
      end
      step();
      tx_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_ready && n < 10) begin n++; @(negedge clk); end
      if (!m_ready) fail("post_out_accept_timeout");
      step();
      m_valid = 1'b0;
      drain();

      // 5: asynchronous reset during READ drops the load.
      grant_q.push_back(2'b10);
      m_req(OP_LOAD, 4'd6, 32'h10, 32'h0, w);
      @(negedge clk);
      chk("read_busy", busy, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst", {busy, cdb_valid, l_rvalid, tx_valid, m_ready, l_ready, ram_en}, 7'h00);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_cdb_after_rst", {cdb_valid, busy}, 2'b00);
      end
      step();
      grant_q.push_back(2'b10);
      cdb_q.push_back({4'd7, 32'h11111111});
      m_req(OP_LOAD, 4'd7, 32'h10, 32'h0, w);
      drain();

      // 6: back-to-back store then load to the same address.
      grant_q.push_back(2'b10);
      m_req(OP_STORE, 4'd0, 32'h30, 32'hCAFEF00D, w);
      grant_q.push_back(2'b10);
      cdb_q.push_back({4'd9, 32'hCAFEF00D});
      m_req(OP_LOAD, 4'd9, 32'h30, 32'h0, w);
      chk("b2b_accept_waits", w, 0);
      drain();

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
